// File: rtl/pwr_seq_ctrl.sv
// Power-sequencing controller for one switchable domain: isolation, retention, switch, reset.
// Define RETENTION_EN to enable the SAVE/RESTORE retention states.
module pwr_seq_ctrl #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned ISO_RST = 2,
  parameter int unsigned SW_RST  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idle,
  input  logic       wake,
  input  logic       pwr_sw_ack,
  input  logic       reg_wr,
  input  logic [7:0] reg_data,
  output logic       pwr_up,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       pwr_sw_en,
  output logic       rst_dom,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StIso     = 3'd1,
    StSave    = 3'd2,
    StPso     = 3'd3,
    StOff     = 3'd4,
    StPon     = 3'd5,
    StRestore = 3'd6,
    StUniso   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sw_dly_q;
  logic [2:0]       iso_dly_q;
  logic             pd_en_q;
  logic             ack_meta_q, ack_sync_q;
  logic             saved_q, saved_d;
  logic             wake_lat_q, wake_lat_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);
  assign state    = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_meta_q <= pwr_sw_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_dly_q  <= 4'(SW_RST);
      iso_dly_q <= 3'(ISO_RST);
      pd_en_q   <= 1'b0;
    end else if (reg_wr) begin
      sw_dly_q  <= reg_data[7:4];
      iso_dly_q <= reg_data[3:1];
      pd_en_q   <= reg_data[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StPon;
      cnt_q      <= CNT_W'(SW_RST);
      saved_q    <= 1'b0;
      wake_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      saved_q    <= saved_d;
      wake_lat_q <= wake_lat_d;
    end
  end

  // Dwell counter loads only on entry to ISO/PON, so cfg writes apply at the next entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    saved_d    = saved_q;
    wake_lat_d = wake_lat_q;
    unique case (state_q)
      StRun: begin
        if (idle && pd_en_q && !wake) begin
          state_d = StIso;
          cnt_d   = CNT_W'(iso_dly_q);
        end
      end
      StIso: begin
        if (wake) begin
          state_d = StUniso;
        end else if (cnt_zero) begin
`ifdef RETENTION_EN
          state_d = StSave;
`else
          state_d = StPso;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StSave: begin
        saved_d    = 1'b1;
        wake_lat_d = wake_lat_q | wake;
        state_d    = StPso;
      end
      StPso: begin
        wake_lat_d = wake_lat_q | wake;
        if (!ack_sync_q) state_d = StOff;
      end
      StOff: begin
        if (wake || wake_lat_q) begin
          state_d    = StPon;
          cnt_d      = CNT_W'(sw_dly_q);
          wake_lat_d = 1'b0;
        end
      end
      StPon: begin
        // Dwell only counts once the rail is confirmed up.
        if (ack_sync_q) begin
          if (cnt_zero) begin
`ifdef RETENTION_EN
            state_d = saved_q ? StRestore : StUniso;
`else
            state_d = StUniso;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      StRestore: begin
        saved_d = 1'b0;
        state_d = StUniso;
      end
      StUniso: state_d = StRun;
      default: state_d = StPon;
    endcase
`ifndef RETENTION_EN
    saved_d = 1'b0;
`endif
  end

  always_comb begin
    pwr_up    = 1'b0;
    iso_en    = 1'b1;
    save      = 1'b0;
    restore   = 1'b0;
    pwr_sw_en = 1'b1;
    rst_dom   = 1'b0;
    unique case (state_q)
      StRun: begin
        pwr_up = 1'b1;
        iso_en = 1'b0;
      end
      StIso: ;
      StSave: begin
`ifdef RETENTION_EN
        save = 1'b1;
`endif
      end
      StPso: pwr_sw_en = 1'b0;
      StOff: begin
        pwr_sw_en = 1'b0;
        rst_dom   = 1'b1;
      end
      StPon: rst_dom = 1'b1;
      StRestore: begin
`ifdef RETENTION_EN
        restore = 1'b1;
`endif
      end
      StUniso: iso_en = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_pwr_seq_ctrl;

`ifdef RETENTION_EN
  localparam bit Ret = 1'b1;
`else
  localparam bit Ret = 1'b0;
`endif

  localparam int SRun = 0, SIso = 1, SSave = 2, SPso = 3;
  localparam int SOff = 4, SPon = 5, SRestore = 6, SUniso = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       idle = 1'b0, wake = 1'b0, ack = 1'b1, reg_wr = 1'b0;
  logic [7:0] reg_data = 8'h00;
  logic       pwr_up, iso_en, save, restore, pwr_sw_en, rst_dom;
  logic [2:0] state;

  pwr_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .idle       (idle),
    .wake       (wake),
    .pwr_sw_ack (ack),
    .reg_wr     (reg_wr),
    .reg_data   (reg_data),
    .pwr_up     (pwr_up),
    .iso_en     (iso_en),
    .save       (save),
    .restore    (restore),
    .pwr_sw_en  (pwr_sw_en),
    .rst_dom    (rst_dom),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_restore = 0;
  bit sw_dropped = 1'b0;
  bit chk_en = 1'b0;

  // Behavioural model: phase, elapsed dwell cycles, captured dwell target, cfg, ack history.
  int m_st = SPon, m_el = 0, m_dly = 3;
  int c_sw = 3, c_iso = 2;
  bit c_pd = 1'b0, m_saved = 1'b0, m_wlat = 1'b0, a1 = 1'b0, a2 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  function automatic logic [5:0] exp_outs(input int s);
    // {pwr_up, iso_en, save, restore, pwr_sw_en, rst_dom}
    case (s)
      SRun:     return 6'b100010;
      SIso:     return 6'b010010;
      SSave:    return 6'b011010;
      SPso:     return 6'b010000;
      SOff:     return 6'b010001;
      SPon:     return 6'b010011;
      SRestore: return 6'b010110;
      default:  return 6'b000010;
    endcase
  endfunction

  task automatic model_reset();
    m_st = SPon; m_el = 0; m_dly = 3;
    c_sw = 3; c_iso = 2; c_pd = 1'b0;
    m_saved = 1'b0; m_wlat = 1'b0; a1 = 1'b0; a2 = 1'b0;
  endtask

  task automatic model_step();
    int ns;
    ns = m_st;
    case (m_st)
      SRun: if (idle && c_pd && !wake) begin ns = SIso; m_dly = c_iso; m_el = 0; end
      SIso: begin
        if (wake) ns = SUniso;
        else if (m_el == m_dly) ns = Ret ? SSave : SPso;
        else m_el++;
      end
      SSave: begin m_saved = 1'b1; if (wake) m_wlat = 1'b1; ns = SPso; end
      SPso: begin if (wake) m_wlat = 1'b1; if (!a2) ns = SOff; end
      SOff: if (wake || m_wlat) begin ns = SPon; m_wlat = 1'b0; m_dly = c_sw; m_el = 0; end
      SPon: begin
        if (a2) begin
          if (m_el == m_dly) ns = m_saved ? SRestore : SUniso;
          else m_el++;
        end
      end
      SRestore: begin m_saved = 1'b0; ns = SUniso; end
      default: ns = SRun;
    endcase
    m_st = ns;
    if (reg_wr) begin
      c_sw = int'(reg_data[7:4]); c_iso = int'(reg_data[3:1]); c_pd = reg_data[0];
    end
    a2 = a1;
    a1 = ack;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("outputs", int'({state, pwr_up, iso_en, save, restore, pwr_sw_en, rst_dom}),
            int'({3'(m_st), exp_outs(m_st)}));
      check("inv_swoff_iso", int'(!pwr_sw_en && !iso_en), 0);
      check("inv_save_restore", int'(save && restore), 0);
      check("inv_pwrup_iso", int'(pwr_up && iso_en), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    if (restore) n_restore++;
    if (!pwr_sw_en) sw_dropped = 1'b1;
  endtask

  task automatic run_until(input int s, input int bound, input string name);
    int n;
    n = 0;
    while (int'(state) != s && n < bound) begin
      tick();
      n++;
    end
    check(name, int'(state), s);
  endtask

  initial begin
    int n;
    reset = 1'b1; ack = 1'b1; idle = 1'b1; wake = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("reset_state", int'(state), SPon);
    check("reset_outs", int'({pwr_up, iso_en, save, restore, pwr_sw_en, rst_dom}), 'b010011);
    reset = 1'b0;

    // 1: default power-up, pd_en=0 keeps it up
    n = 0;
    while (!pwr_up && n < 20) begin tick(); n++; end
    check("t1_pwrup_latency", n, 7);
    n = 0;
    repeat (10) begin tick(); if (pwr_up) n++; end
    check("t1_stays_up", n, 10);

    // 2: enable power-down with iso_dly=0
    reg_wr = 1'b1; reg_data = 8'h21; tick(); reg_wr = 1'b0;
    check("t2_still_run", int'(state), SRun);
    tick();
    check("t2_iso", int'(state), SIso);
    tick();
    check("t2_after_iso", int'(state), Ret ? SSave : SPso);
    run_until(SPso, 2, "t2_pso");
    ack = 1'b0;
    run_until(SOff, 6, "t2_off");

    // 4: wake from OFF, ack rises 4 cycles later
    reg_wr = 1'b1; reg_data = 8'h2F; tick(); reg_wr = 1'b0;
    check("t4_off_hold", int'(state), SOff);
    wake = 1'b1; tick(); wake = 1'b0;
    check("t4_pon", int'(state), SPon);
    n_restore = 0;
    repeat (3) tick();
    check("t4_wait_ack", int'(state), SPon);
    ack = 1'b1;
    n = 0;
    while (!pwr_up && n < 30) begin tick(); n++; end
    check("t4_latency", n, 6 + int'(Ret));
    check("t4_restores", n_restore, int'(Ret));

    // 3: abort ISO (iso_dly=7) with wake on dwell cycle 3
    sw_dropped = 1'b0;
    tick();
    check("t3_iso", int'(state), SIso);
    tick(); tick();
    wake = 1'b1; tick(); wake = 1'b0;
    check("t3_uniso", int'(state), SUniso);
    tick();
    check("t3_run", int'(state), SRun);
    check("t3_sw_kept", int'(sw_dropped), 0);

    // 5: wake latched in PSO
    run_until(SPso, 20, "t5_pso");
    tick();
    wake = 1'b1; tick(); wake = 1'b0;
    tick();
    check("t5_pso_hold", int'(state), SPso);
    ack = 1'b0;
    run_until(SOff, 6, "t5_off");
    tick();
    check("t5_auto_pon", int'(state), SPon);
    ack = 1'b1; idle = 1'b0;
    run_until(SRun, 40, "t5_run");

    // 6a: reset in SAVE (ISO without retention)
    idle = 1'b1;
    run_until(Ret ? SSave : SIso, 20, "t6a_target");
    reset = 1'b1; tick();
    check("t6a_pon", int'(state), SPon);
    check("t6a_iso", int'(iso_en), 1);
    reset = 1'b0; idle = 1'b0; n_restore = 0;
    run_until(SRun, 40, "t6a_run");
    check("t6a_no_restore", n_restore, 0);

    // 6b: reset in OFF
    reg_wr = 1'b1; reg_data = 8'h21; idle = 1'b1; tick(); reg_wr = 1'b0;
    run_until(SPso, 20, "t6b_pso");
    ack = 1'b0;
    run_until(SOff, 6, "t6b_off");
    reset = 1'b1; tick();
    check("t6b_pon", int'(state), SPon);
    check("t6b_iso", int'(iso_en), 1);
    ack = 1'b1; reset = 1'b0; n_restore = 0;
    run_until(SRun, 40, "t6b_run");
    check("t6b_no_restore", n_restore, 0);

    // Randomized traffic; the switch follows pwr_sw_en after a random delay
    for (int i = 0; i < 4000; i++) begin
      idle     = ($urandom_range(0, 3) != 0);
      wake     = ($urandom_range(0, 7) == 0);
      reg_wr   = ($urandom_range(0, 31) == 0);
      reg_data = 8'($urandom);
      reg_data[0] = ($urandom_range(0, 3) != 0);
      if (ack != pwr_sw_en && $urandom_range(0, 2) == 0) ack = pwr_sw_en;
      reset    = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0; reg_wr = 1'b0; wake = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
